// File: rtl/saturn_bus_arbiter.sv
// Shares the HP48 nibble bus between instruction fetch and ALU DP transfers.
// Define SATURN_BUS_PTR_CACHE_EN to let sequential fetches skip the PC reload.
module saturn_bus_arbiter #(
  parameter int unsigned ADDR_W    = 20,
  parameter logic [1:0]  STROBE_PH = 2'd0
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [1:0]        i_phase,
  input  logic              i_fetch_req,
  input  logic [ADDR_W-1:0] i_fetch_addr,
  output logic              o_fetch_valid,
  output logic [3:0]        o_fetch_nibble,
  input  logic              i_data_req,
  input  logic              i_data_write,
  input  logic [ADDR_W-1:0] i_data_addr,
  input  logic [3:0]        i_data_cnt,
  input  logic [3:0]        i_data_nibble,
  output logic              o_data_next,
  output logic              o_data_valid,
  output logic [3:0]        o_data_nibble,
  output logic              o_data_done,
  output logic              o_busy,
  output logic              o_bus_strobe,
  output logic              o_bus_cmd_data,
  output logic [3:0]        o_bus_data,
  input  logic [3:0]        i_bus_data
);

  localparam int unsigned NIB_N   = 5;
  localparam int unsigned ADDR_PW = 4 * NIB_N;

  localparam logic [3:0] BUSCMD_DP_WRITE = 4'h5;
  localparam logic [3:0] BUSCMD_LOAD_PC  = 4'h6;
  localparam logic [3:0] BUSCMD_LOAD_DP  = 4'h7;

  typedef enum logic [2:0] {IDLE, CMD, ADDR, WCMD, XFR} state_t;
  typedef enum logic {MODE_PC, MODE_DP} mode_t;

  state_t            state, eff_state;
  mode_t             dev_mode;
  logic [ADDR_W-1:0] dev_ptr, addr_q;
  logic [ADDR_PW-1:0] addr_ext;
  logic [3:0]        addr_nib, xfr_cnt, eff_cnt;
  logic [2:0]        nib_idx;
  logic              is_data_q, write_q, xfr_end, eff_end, issued;
  logic              slot, samp, pc_ok, hit;
  logic              grant_data, grant_fetch, cur_data, cur_write;

  assign slot     = (i_phase == STROBE_PH);
  assign samp     = (i_phase == 2'(STROBE_PH + 2'd1));
  assign addr_ext = ADDR_PW'(addr_q);
  assign addr_nib = 4'(addr_ext >> {nib_idx, 2'b00});

  // Grant decode; a grant acts on its own slot so a cached fetch costs one bus cycle
  always_comb begin
    grant_data  = (state == IDLE) && slot && i_data_req;
    grant_fetch = (state == IDLE) && slot && !i_data_req && i_fetch_req;
    hit         = pc_ok && (dev_mode == MODE_PC) && (dev_ptr == i_fetch_addr);
    cur_data    = grant_data | (!grant_fetch & is_data_q);
    cur_write   = grant_data ? i_data_write : (!grant_fetch & write_q);
    eff_cnt     = grant_data ? i_data_cnt : (grant_fetch ? 4'd0 : xfr_cnt);
    eff_end     = (grant_data || grant_fetch) ? 1'b0 : xfr_end;
    if (grant_data)       eff_state = CMD;
    else if (grant_fetch) eff_state = hit ? XFR : CMD;
    else                  eff_state = state;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state          <= IDLE;
      dev_mode       <= MODE_PC;
      dev_ptr        <= '0;
      addr_q         <= '0;
      xfr_cnt        <= 4'd0;
      nib_idx        <= 3'd0;
      is_data_q      <= 1'b0;
      write_q        <= 1'b0;
      xfr_end        <= 1'b0;
      issued         <= 1'b0;
`ifdef SATURN_BUS_PTR_CACHE_EN
      pc_ok          <= 1'b0;
`endif
      o_fetch_valid  <= 1'b0;
      o_fetch_nibble <= 4'd0;
      o_data_next    <= 1'b0;
      o_data_valid   <= 1'b0;
      o_data_nibble  <= 4'd0;
      o_data_done    <= 1'b0;
      o_busy         <= 1'b0;
      o_bus_strobe   <= 1'b0;
      o_bus_cmd_data <= 1'b0;
      o_bus_data     <= 4'd0;
    end else begin
      o_bus_strobe  <= 1'b0;
      o_fetch_valid <= 1'b0;
      o_data_valid  <= 1'b0;
      o_data_next   <= 1'b0;
      o_data_done   <= 1'b0;

      if (grant_data || grant_fetch) begin
        is_data_q <= grant_data;
        write_q   <= grant_data & i_data_write;
        addr_q    <= grant_data ? i_data_addr : i_fetch_addr;
        xfr_cnt   <= grant_data ? i_data_cnt : 4'd0;
        xfr_end   <= 1'b0;
        issued    <= 1'b0;
        o_busy    <= 1'b1;
      end

      if (slot) begin
        case (eff_state)
          CMD: begin
            o_bus_strobe   <= 1'b1;
            o_bus_cmd_data <= 1'b0;
            o_bus_data     <= cur_data ? BUSCMD_LOAD_DP : BUSCMD_LOAD_PC;
            dev_mode       <= cur_data ? MODE_DP : MODE_PC;
`ifdef SATURN_BUS_PTR_CACHE_EN
            pc_ok          <= 1'b0;
`endif
            nib_idx        <= 3'd0;
            state          <= ADDR;
          end
          ADDR: begin
            o_bus_strobe   <= 1'b1;
            o_bus_cmd_data <= 1'b1;
            o_bus_data     <= addr_nib;
            nib_idx        <= nib_idx + 3'd1;
            // Device switches to the read mode on its own after the 5th nibble
            if (nib_idx == 3'(NIB_N - 1)) begin
              dev_ptr <= addr_q;
`ifdef SATURN_BUS_PTR_CACHE_EN
              pc_ok   <= (dev_mode == MODE_PC);
`endif
              state   <= write_q ? WCMD : XFR;
            end
          end
          WCMD: begin
            o_bus_strobe   <= 1'b1;
            o_bus_cmd_data <= 1'b0;
            o_bus_data     <= BUSCMD_DP_WRITE;
            state          <= XFR;
          end
          XFR: begin
            if (!eff_end) begin
              o_bus_strobe   <= 1'b1;
              o_bus_cmd_data <= 1'b1;
              o_bus_data     <= cur_write ? i_data_nibble : 4'd0;
              dev_ptr        <= dev_ptr + ADDR_W'(1);
              xfr_cnt        <= eff_cnt - 4'd1;
              xfr_end        <= (eff_cnt == 4'd0);
              issued         <= 1'b1;
              state          <= XFR;
            end
          end
          default: ;
        endcase
      end

      // Clock after each data strobe: capture read nibble or acknowledge write
      if (samp && (state == XFR) && issued) begin
        issued <= 1'b0;
        if (write_q) begin
          o_data_next <= 1'b1;
        end else if (is_data_q) begin
          o_data_valid  <= 1'b1;
          o_data_nibble <= i_bus_data;
        end else begin
          o_fetch_valid  <= 1'b1;
          o_fetch_nibble <= i_bus_data;
        end
        if (xfr_end) begin
          state       <= IDLE;
          o_busy      <= 1'b0;
          o_data_done <= is_data_q;
        end
      end
    end
  end

`ifndef SATURN_BUS_PTR_CACHE_EN
  assign pc_ok = 1'b0;
`endif

endmodule

// File: tb/tb_saturn_bus_arbiter.sv
// Directed bench for saturn_bus_arbiter with a behavioural nibble-bus device.
module tb_saturn_bus_arbiter;

  logic        clk = 1'b0;
  logic        i_reset = 1'b1;
  logic [1:0]  i_phase = 2'd0;
  logic        i_fetch_req = 1'b0;
  logic [19:0] i_fetch_addr = '0;
  logic        i_data_req = 1'b0;
  logic        i_data_write = 1'b0;
  logic [19:0] i_data_addr = '0;
  logic [3:0]  i_data_cnt = '0;
  logic [3:0]  i_data_nibble = '0;
  logic [3:0]  i_bus_data = '0;
  logic        o_fetch_valid, o_data_next, o_data_valid, o_data_done, o_busy;
  logic        o_bus_strobe, o_bus_cmd_data;
  logic [3:0]  o_fetch_nibble, o_data_nibble, o_bus_data;

  saturn_bus_arbiter #(.ADDR_W(20), .STROBE_PH(2'd0)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_phase(i_phase),
    .i_fetch_req(i_fetch_req), .i_fetch_addr(i_fetch_addr),
    .o_fetch_valid(o_fetch_valid), .o_fetch_nibble(o_fetch_nibble),
    .i_data_req(i_data_req), .i_data_write(i_data_write),
    .i_data_addr(i_data_addr), .i_data_cnt(i_data_cnt),
    .i_data_nibble(i_data_nibble), .o_data_next(o_data_next),
    .o_data_valid(o_data_valid), .o_data_nibble(o_data_nibble),
    .o_data_done(o_data_done), .o_busy(o_busy),
    .o_bus_strobe(o_bus_strobe), .o_bus_cmd_data(o_bus_cmd_data),
    .o_bus_data(o_bus_data), .i_bus_data(i_bus_data)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Device: rom content a[3:0]^a[11:8]^a[19:16]^9, overridden by writes
  function automatic logic [3:0] rom(input logic [19:0] a);
    return a[3:0] ^ a[11:8] ^ a[19:16] ^ 4'h9;
  endfunction

  logic [4:0]  items[$];
  logic [4:0]  expq[$];
  logic [3:0]  rdq[$];
  logic [3:0]  wmem[int];
  logic [3:0]  wdat[16];
  logic [19:0] d_ptr = '0;
  int          d_mode = 0;
  int          d_n = 0;
  int          cyc = 0;
  int          last_strobe_cyc = 0;

  // Phase generator, bus recorder and device model
  always @(negedge clk) begin
    cyc++;
    i_phase = i_phase + 2'd1;
    if (o_bus_strobe) begin
      items.push_back({o_bus_cmd_data, o_bus_data});
      last_strobe_cyc = cyc;
      if (!o_bus_cmd_data) begin
        case (o_bus_data)
          4'h6: begin d_mode = 1; d_n = 0; end
          4'h7: begin d_mode = 2; d_n = 0; end
          4'h5: d_mode = 5;
          default: d_mode = 0;
        endcase
      end else begin
        case (d_mode)
          1, 2: begin
            d_ptr[4*d_n +: 4] = o_bus_data;
            d_n++;
            if (d_n == 5) d_mode = d_mode + 2;
          end
          3, 4: begin
            i_bus_data = wmem.exists(int'(d_ptr)) ? wmem[int'(d_ptr)] : rom(d_ptr);
            d_ptr++;
          end
          5: begin
            wmem[int'(d_ptr)] = o_bus_data;
            d_ptr++;
          end
          default: ;
        endcase
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check_items(input string tag);
    check({tag, "_len"}, items.size(), expq.size());
    for (int k = 0; k < expq.size(); k++)
      check($sformatf("%s_item%0d", tag, k),
            (k < items.size()) ? 32'(items[k]) : 32'hDEAD, 32'(expq[k]));
    items.delete();
  endtask

  task automatic do_fetch(input logic [19:0] a, output logic [3:0] nib, output int lat);
    bit got;
    got = 1'b0;
    items.delete();
    i_fetch_addr = a;
    i_fetch_req  = 1'b1;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (o_fetch_valid) begin got = 1'b1; break; end
    end
    i_fetch_req = 1'b0;
    nib = o_fetch_nibble;
    lat = cyc - last_strobe_cyc;
    check("fetch_done", 32'(got), 32'd1);
  endtask

  task automatic do_data(input bit wr, input logic [19:0] a, input logic [3:0] cnt,
                         output int n_next, output int n_done);
    int  widx;
    bit  fin;
    widx = 0; fin = 1'b0; n_next = 0; n_done = 0;
    rdq.delete();
    items.delete();
    i_data_write  = wr;
    i_data_addr   = a;
    i_data_cnt    = cnt;
    i_data_nibble = wdat[0];
    i_data_req    = 1'b1;
    for (int k = 0; k < 200; k++) begin
      tick();
      if (o_data_valid) rdq.push_back(o_data_nibble);
      if (o_data_next) begin
        n_next++;
        widx++;
        if (widx < 16) i_data_nibble = wdat[widx];
      end
      if (o_data_done) begin n_done++; fin = 1'b1; break; end
    end
    i_data_req = 1'b0;
    check("data_done", 32'(fin), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] nib;
    int         lat, nn, nd, dd;
    bit         fv;

    repeat (3) tick();
    check("reset_outs", {o_fetch_valid, o_fetch_nibble, o_data_next, o_data_valid,
                         o_data_nibble, o_data_done, o_busy, o_bus_strobe,
                         o_bus_cmd_data, o_bus_data}, 32'd0);
    i_reset = 1'b0;
    tick();

    // Cold fetch: LOAD_PC, address low nibble first, one PC read
    do_fetch(20'h12345, nib, lat);
    expq = '{5'h06, 5'h15, 5'h14, 5'h13, 5'h12, 5'h11, 5'h10};
    check_items("fetchA");
    check("fetchA_nib", nib, 4'hE);
    check("fetchA_lat", lat, 1);
    check("fetchA_idle", o_busy, 1'b0);

    // Sequential fetch
    do_fetch(20'h12346, nib, lat);
`ifdef SATURN_BUS_PTR_CACHE_EN
    expq = '{5'h10};
`else
    expq = '{5'h06, 5'h16, 5'h14, 5'h13, 5'h12, 5'h11, 5'h10};
`endif
    check_items("fetchB");
    check("fetchB_nib", nib, 4'hD);
    check("fetchB_lat", lat, 1);

    // Fetch and data read requested together: data first, then fetch reloads
    items.delete();
    rdq.delete();
    dd = 0; fv = 1'b0; nib = 4'd0;
    i_fetch_addr = 20'h12347; i_fetch_req = 1'b1;
    i_data_write = 1'b0; i_data_addr = 20'h00100; i_data_cnt = 4'd2; i_data_req = 1'b1;
    for (int k = 0; k < 300; k++) begin
      tick();
      if (o_data_valid) rdq.push_back(o_data_nibble);
      if (o_data_done) begin dd++; i_data_req = 1'b0; end
      if (o_fetch_valid) begin fv = 1'b1; nib = o_fetch_nibble; break; end
    end
    i_fetch_req = 1'b0;
    expq = '{5'h07, 5'h10, 5'h10, 5'h11, 5'h10, 5'h10, 5'h10, 5'h10, 5'h10,
             5'h06, 5'h17, 5'h14, 5'h13, 5'h12, 5'h11, 5'h10};
    check_items("arb");
    check("arb_done_cnt", dd, 1);
    check("arb_fetch_done", 32'(fv), 32'd1);
    check("arb_rd_len", rdq.size(), 3);
    check("arb_rd0", (rdq.size() > 0) ? 32'(rdq[0]) : 32'hDEAD, 32'h8);
    check("arb_rd1", (rdq.size() > 1) ? 32'(rdq[1]) : 32'hDEAD, 32'h9);
    check("arb_rd2", (rdq.size() > 2) ? 32'(rdq[2]) : 32'hDEAD, 32'hA);
    check("arb_fetch_nib", nib, 4'hC);

    // Two-nibble write, then read back
    wdat[0] = 4'hA; wdat[1] = 4'hB;
    do_data(1'b1, 20'h80000, 4'd1, nn, nd);
    expq = '{5'h07, 5'h10, 5'h10, 5'h10, 5'h10, 5'h18, 5'h05, 5'h1A, 5'h1B};
    check_items("write");
    check("write_next", nn, 2);
    check("write_done", nd, 1);

    do_data(1'b0, 20'h80000, 4'd1, nn, nd);
    expq = '{5'h07, 5'h10, 5'h10, 5'h10, 5'h10, 5'h18, 5'h10, 5'h10};
    check_items("rdback");
    check("rdback_len", rdq.size(), 2);
    check("rdback0", (rdq.size() > 0) ? 32'(rdq[0]) : 32'hDEAD, 32'hA);
    check("rdback1", (rdq.size() > 1) ? 32'(rdq[1]) : 32'hDEAD, 32'hB);

    // Pointer wrap from 0xFFFFF to 0x00000
    do_fetch(20'hFFFFF, nib, lat);
    expq = '{5'h06, 5'h1F, 5'h1F, 5'h1F, 5'h1F, 5'h1F, 5'h10};
    check_items("wrapA");
    check("wrapA_nib", nib, 4'h6);
    do_fetch(20'h00000, nib, lat);
`ifdef SATURN_BUS_PTR_CACHE_EN
    expq = '{5'h10};
`else
    expq = '{5'h06, 5'h10, 5'h10, 5'h10, 5'h10, 5'h10, 5'h10};
`endif
    check_items("wrapB");
    check("wrapB_nib", nib, 4'h9);

    // Reset during the 3rd address nibble
    items.delete();
    i_fetch_addr = 20'h12348; i_fetch_req = 1'b1;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (items.size() >= 4) break;
    end
    check("rst_reach", items.size(), 4);
    i_reset = 1'b1;
    tick();
    check("rst_outs", {o_fetch_valid, o_fetch_nibble, o_data_next, o_data_valid,
                       o_data_nibble, o_data_done, o_busy, o_bus_strobe,
                       o_bus_cmd_data, o_bus_data}, 32'd0);
    i_reset = 1'b0;
    i_fetch_req = 1'b0;
    repeat (4) tick();
    do_fetch(20'h12348, nib, lat);
    expq = '{5'h06, 5'h18, 5'h14, 5'h13, 5'h12, 5'h11, 5'h10};
    check_items("postrst");
    check("postrst_nib", nib, 4'h3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/saturn_bus_arbiter.md
Name: saturn_bus_arbiter

Overview:
- Sequences and shares the HP48 nibble bus between two requesters: the instruction fetch port (PC stream) and the ALU memory-transfer port (DP read/write).
- Turns each request into bus items (command nibble, 5 address nibbles, data nibbles) and issues at most one item per bus cycle on the strobe phase.
- Tracks the device's PC/DP pointer and mode so that a sequential fetch costs one bus cycle.
- Sits between saturn_decoder/saturn_alu and the external bus pins, in place of the ad-hoc command logic.

Parameters:
- ADDR_W, 20, address width; always sent as 5 nibbles, low nibble first.
- STROBE_PH, 0, value of i_phase at which a bus item is issued.

Ports:
- i_clk  in  1  core clock
- i_reset  in  1  synchronous, active-high reset
- i_phase  in  2  core clock phase, advances by 1 per clock
- i_fetch_req  in  1  fetch request, held until o_fetch_valid
- i_fetch_addr  in  ADDR_W  nibble address to fetch
- o_fetch_valid  out  1  1-clock pulse, o_fetch_nibble valid
- o_fetch_nibble  out  4  fetched nibble
- i_data_req  in  1  transfer request, held until o_data_done
- i_data_write  in  1  1 = write, 0 = read
- i_data_addr  in  ADDR_W  start address
- i_data_cnt  in  4  nibble count minus 1 (1..16 nibbles)
- i_data_nibble  in  4  write nibble, sampled at each write slot
- o_data_next  out  1  1-clock pulse after a write nibble is consumed
- o_data_valid  out  1  1-clock pulse, o_data_nibble valid (read)
- o_data_nibble  out  4  read nibble
- o_data_done  out  1  1-clock pulse, transfer complete
- o_busy  out  1  FSM not in IDLE
- o_bus_strobe  out  1  bus strobe
- o_bus_cmd_data  out  1  0 = command nibble, 1 = address/data nibble
- o_bus_data  out  4  nibble to device
- i_bus_data  in  4  nibble from device

Behaviour:

Reset:
- All outputs 0.
- FSM enters IDLE; pointer-valid flags cleared; transfer counter cleared.
- Reset mid-transaction aborts it; no done/valid pulse is produced.

Slots:
- A slot is a clock with i_phase == STROBE_PH.
- When an item is issued, o_bus_strobe is high for that clock only.
- o_bus_cmd_data and o_bus_data are set on the same clock and held until the next slot.
- Read data is sampled from i_bus_data on the clock where i_phase == STROBE_PH+1 (mod 4); the valid pulse is asserted on that clock.

Arbitration:
- Decided only in IDLE at a slot.
- Data wins over fetch.
- A granted request runs to completion.
- Fetch is one nibble per grant, so a pending data request waits at most one fetch.

FSM states: IDLE, CMD, ADDR, WCMD, XFR.

Fetch path:
- If pc_ok is set, dev_mode == PC and dev_ptr == i_fetch_addr: go to XFR directly, issuing a PC_READ data strobe.
- Otherwise: CMD issues `BUSCMD_LOAD_PC, then ADDR issues 5 address nibbles, then XFR. The device auto-switches to PC_READ after the 5th nibble.

Data read path:
- CMD issues `BUSCMD_LOAD_DP, then 5 ADDR nibbles (device auto-switches to DP_READ), then XFR for i_data_cnt+1 slots.

Data write path:
- CMD, then ADDR, then WCMD issues `BUSCMD_DP_WRITE, then XFR for i_data_cnt+1 slots.
- i_data_nibble drives o_bus_data at each slot.
- o_data_next pulses on the following clock.

Completion and pointer tracking:
- o_data_done pulses together with the last o_data_valid (read), or on the clock after the last write slot.
- dev_ptr increments by 1 (mod 2^ADDR_W, so 0xFFFFF wraps to 0x00000) on every data strobe.
- dev_mode is set to PC or DP by the load, and pc_ok is updated accordingly.
- Any DP transaction sets dev_mode = DP, which forces the next fetch to reload.
- Requests asserted during a non-slot clock wait for the next slot.
- Requests dropped before grant are ignored.

Optional Feature:
- Macro: SATURN_BUS_PTR_CACHE_EN.
- Defined: sequential fetches skip reload as described in Fetch path.
- Undefined: every fetch and every data transfer issues the full command and 5 address nibbles; pc_ok is tied to 0.

Test Plan:
- After reset, fetch at 0x12345: slots carry cmd 6, then data 5, 4, 3, 2, 1, then one read strobe. o_fetch_valid fires 1 clock after the 7th slot with rom[0x12345].
- Next fetch at 0x12346 with the cache enabled: single data strobe, valid after 1 slot. With the cache disabled: 7 slots.
- Fetch and data read (0x00100, cnt=2) asserted in the same slot: data granted first with cmd 7, address 0, 0, 1, 0, 0, then 3 reads; o_data_done on the 3rd valid. The fetch then reloads with LOAD_PC.
- Write 2 nibbles A, B to 0x80000: cmd 7, address 0, 0, 0, 0, 8, then cmd 5, then data A, B. o_data_next pulses twice; o_data_done follows.
- Fetch at 0xFFFFF followed by fetch at 0x00000: the second fetch uses no reload, confirming wrap.
- i_reset asserted during the 3rd address nibble: all outputs 0 on the next clock. A later fetch at the same address issues a full LOAD_PC.
